// File: rtl/instr_mem_loader.sv
// instr_mem_loader: serial boot loader for the instruction memory.
//
// Receives 8N1 bytes on rx and packs them big-endian into 32-bit words. The
// first word is the image length N. The next N words are written to
// instruction memory at byte addresses 0, 4, 8, ... using one-cycle write
// strobes. Words whose index is MEM_WORDS or above are counted but not
// written. cpuReset stays high, and done stays low, until all N words have
// arrived.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset; restarts at the header
//   rx           serial input, idle high, asynchronous to clock
//   writeEnable  one-cycle write strobe
//   writeAddress word-aligned byte address of the write
//   writeData    assembled instruction word
//   cpuReset     core reset, released once the image is loaded
//   done         sticky load-complete flag
//   frameError   sticky flag, set when any stop bit samples low
module instr_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_WORDS    = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        writeEnable,
  output logic [31:0] writeAddress,
  output logic [31:0] writeData,
  output logic        cpuReset,
  output logic        done,
  output logic        frameError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;
  typedef enum logic [1:0] {LD_HEADER, LD_LOAD, LD_FINISHED} load_state_t;

  logic             rx_meta, rx_sync;
  bit_state_t       bit_state, bit_next;
  load_state_t      load_state, load_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [31:0]      n_words;
  logic [31:0]      word_index;
  logic             full_tick, half_tick;
  logic             byte_valid, stop_bad;
  logic             word_done, in_mem;
  logic [31:0]      full_word;

  assign full_tick = (clk_cnt == FULL_LAST);
  assign half_tick = (clk_cnt == HALF_LAST);
  // The shift register holds the newest byte; word_buf holds the older three.
  assign full_word = {word_buf, shift_reg};
  assign word_done = byte_valid && (byte_cnt == 2'd3);
  assign in_mem    = (word_index < 32'(MEM_WORDS));

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit FSM next state, plus the byte-valid and framing-error pulses.
  always_comb begin
    bit_next   = bit_state;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (bit_state)
      BIT_IDLE: begin
        if (!rx_sync) bit_next = BIT_START;
        else          bit_next = BIT_IDLE;
      end
      BIT_START: begin
        // A start bit that has gone high again by mid-bit is a glitch.
        if (half_tick) bit_next = rx_sync ? BIT_IDLE : BIT_DATA;
        else           bit_next = BIT_START;
      end
      BIT_DATA: begin
        if (full_tick && (bit_cnt == 3'd7)) bit_next = BIT_STOP;
        else                                bit_next = BIT_DATA;
      end
      BIT_STOP: begin
        if (full_tick) begin
          bit_next   = BIT_IDLE;
          byte_valid = rx_sync;
          stop_bad   = !rx_sync;
        end else begin
          bit_next = BIT_STOP;
        end
      end
      default: bit_next = BIT_IDLE;
    endcase
  end

  // Bit FSM state register, bit timing counter and data shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_state <= BIT_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      bit_state <= bit_next;
      // Restart the bit timer on every state change and at each full-bit sample.
      if ((bit_state == BIT_IDLE) || (bit_next != bit_state) || full_tick)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (bit_state == BIT_START)
        bit_cnt <= 3'd0;
      else if ((bit_state == BIT_DATA) && full_tick)
        bit_cnt <= bit_cnt + 3'd1;
      // Serial data arrives LSB first, so bits are shifted in from the top.
      if ((bit_state == BIT_DATA) && full_tick)
        shift_reg <= {rx_sync, shift_reg[7:1]};
    end
  end

  // Word assembly. A byte discarded for a bad stop bit never gets here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word_buf <= 24'h000000;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      word_buf <= {word_buf[15:0], shift_reg};
    end
  end

  // Load FSM next state.
  always_comb begin
    load_next = load_state;
    case (load_state)
      LD_HEADER: begin
        if (word_done) load_next = (full_word == 32'd0) ? LD_FINISHED : LD_LOAD;
        else           load_next = LD_HEADER;
      end
      LD_LOAD: begin
        // word_index has already advanced past the final word by the strobe cycle.
        if (word_index == n_words) load_next = LD_FINISHED;
        else                       load_next = LD_LOAD;
      end
      LD_FINISHED: load_next = LD_FINISHED;
      default:     load_next = LD_HEADER;
    endcase
  end

  // Load FSM state, word bookkeeping and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_state   <= LD_HEADER;
      n_words      <= 32'd0;
      word_index   <= 32'd0;
      writeEnable  <= 1'b0;
      writeAddress <= 32'd0;
      writeData    <= 32'd0;
      cpuReset     <= 1'b1;
      done         <= 1'b0;
      frameError   <= 1'b0;
    end else begin
      load_state  <= load_next;
      writeEnable <= (load_state == LD_LOAD) && word_done && in_mem;
      if ((load_state == LD_HEADER) && word_done) begin
        n_words    <= full_word;
        word_index <= 32'd0;
      end
      if ((load_state == LD_LOAD) && word_done) begin
        word_index <= word_index + 32'd1;
        if (in_mem) begin
          writeData    <= full_word;
          writeAddress <= {word_index[29:0], 2'b00};
        end
      end
      done       <= (load_next == LD_FINISHED);
      cpuReset   <= (load_next != LD_FINISHED);
      frameError <= frameError | stop_bad;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (CLKS_PER_BIT=4, MEM_WORDS=2).
// The reference model derives the expected writes directly from the image:
// the first word is N, data word i is written at i*4 when i < N and
// i < MEM_WORDS, and anything after N words produces no write.
module tb_instr_mem_loader;
  localparam int CPB = 4;
  localparam int MW  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        writeEnable;
  logic [31:0] writeAddress;
  logic [31:0] writeData;
  logic        cpuReset;
  logic        done;
  logic        frameError;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_strobe_cyc = -100;
  bit          tight_check = 1'b0;
  bit          prev_we = 1'b0;
  bit          prev_done = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] img[$];

  instr_mem_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .cpuReset(cpuReset), .done(done), .frameError(frameError)
  );

  always #5 clock = ~clock;

  // Monitor: compares every strobe against the scoreboard and checks done timing.
  always @(negedge clock) begin
    logic [63:0] e;
    cyc++;
    if (!reset) begin
      if (writeEnable) begin
        total++;
        if (prev_we) begin
          bad++;
          $display("FAIL strobe_width: writeEnable high on consecutive cycles, required single cycle");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", writeAddress, writeData);
        end else begin
          e = exp_q.pop_front();
          if ({writeAddress, writeData} !== e) begin
            bad++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     writeAddress, writeData, e[63:32], e[31:0]);
          end
        end
        last_strobe_cyc = cyc;
      end
      if (done && !prev_done && tight_check) begin
        total++;
        if (cyc - last_strobe_cyc != 1) begin
          bad++;
          $display("FAIL done_timing: done rose %0d cycles after last strobe, required 1",
                   cyc - last_strobe_cyc);
        end
      end
    end
    prev_we   = writeEnable;
    prev_done = done;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_we",    {31'd0, writeEnable}, 32'd0);
    chk("rst_addr",  writeAddress, 32'd0);
    chk("rst_data",  writeData, 32'd0);
    chk("rst_cpu",   {31'd0, cpuReset}, 32'd1);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_ferr",  {31'd0, frameError}, 32'd0);
    exp_q.delete();
    tight_check     = 1'b0;
    last_strobe_cyc = -100;
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = good;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    if (!good) repeat (2 * CPB) @(negedge clock);
  endtask

  // Sends a word MSB byte first; byte bad_byte is first sent with a low stop bit.
  task automatic send_word(input logic [31:0] w, input int bad_byte);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[31 - 8 * k -: 8];
      if (k == bad_byte) send_byte(b, 1'b0);
      send_byte(b, 1'b1);
    end
  endtask

  // img[0] is N, followed by data words (possibly more than N).
  task automatic run_image(input int bad_word, input int bad_byte, input bit exp_fe);
    int n;
    int c;
    n = int'(img[0]);
    tight_check = (n > 0) && (n <= MW);
    send_word(img[0], (bad_word == 0) ? bad_byte : -1);
    for (int i = 1; i < img.size(); i++) begin
      if ((i - 1) < n && (i - 1) < MW)
        exp_q.push_back({32'((i - 1) * 4), img[i]});
      send_word(img[i], (bad_word == i) ? bad_byte : -1);
    end
    c = 0;
    while (!done && c < 40) begin
      @(negedge clock);
      c++;
    end
    repeat (2) @(negedge clock);
    chk("done",      {31'd0, done}, 32'd1);
    chk("cpu_reset", {31'd0, cpuReset}, 32'd0);
    chk("frame_err", {31'd0, frameError}, {31'd0, exp_fe});
    chk("pending_writes", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    int bw;
    int bb;
    reset = 1'b1;
    rx    = 1'b1;
    do_reset();

    // Two-word image plus trailing traffic after the load completes.
    img = '{32'd2, 32'h8C010004, 32'h00221820, 32'h12345678};
    run_image(-1, -1, 1'b0);

    // Zero-length header.
    do_reset();
    img = '{32'd0, 32'hCAFEF00D};
    run_image(-1, -1, 1'b0);

    // Framing error on the second byte of a data word, then resent.
    do_reset();
    img = '{32'd2, 32'h8C010004, 32'h00221820};
    run_image(2, 1, 1'b1);

    // More words than the memory holds.
    do_reset();
    img = '{32'd3, 32'h11111111, 32'h22222222, 32'h33333333};
    run_image(-1, -1, 1'b0);

    // Reset in the middle of the third byte of the first data word.
    do_reset();
    send_word(32'd2, -1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    rx = 1'b0;
    repeat (5) @(negedge clock);
    do_reset();
    img = '{32'd1, 32'hDEADBEEF};
    run_image(-1, -1, 1'b0);

    // One-cycle glitch while idle is rejected without side effects.
    do_reset();
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_ferr", {31'd0, frameError}, 32'd0);
    img = '{32'd1, 32'h0BADC0DE};
    run_image(-1, -1, 1'b0);

    // Randomized images, optional framing error, optional trailing word.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(0, 4);
      img.delete();
      img.push_back(32'(n));
      for (int i = 0; i < n; i++) img.push_back($urandom());
      if ($urandom_range(0, 1) == 1) img.push_back($urandom());
      if ($urandom_range(0, 1) == 1) begin
        bw = $urandom_range(0, img.size() - 1);
        bb = $urandom_range(0, 3);
      end else begin
        bw = -1;
        bb = -1;
      end
      run_image(bw, bb, bw >= 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Serial boot loader that writes program images into instruction memory before the pipeline runs. The pipeline core only reads instruction memory; this block is the matching writer.
- Receives 8N1 serial bytes on rx.
- Assembles them into 32-bit words and issues single-cycle write strobes with byte addresses.
- Holds the CPU in reset until the whole image is loaded.
- Sits between the FPGA serial pin and the instruction memory write port, beside the core top level.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 4
MEM_WORDS, 256, instruction memory depth in 32-bit words; words at index >= MEM_WORDS are received but not written

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state, loader restarts waiting for header
rx  input  1  serial data, idle high, asynchronous to clock
writeEnable  output  1  one-cycle strobe: write writeData at writeAddress
writeAddress  output  32  byte address, always word aligned (bits 1:0 = 0)
writeData  output  32  assembled instruction word
cpuReset  output  1  high from reset until load completes; drives core reset
done  output  1  high once image fully loaded; sticky until reset
frameError  output  1  sticky; set when any stop bit samples low

Behaviour:
Reset values:
- writeEnable=0, writeAddress=0, writeData=0.
- cpuReset=1, done=0, frameError=0.
- rx synchronizer flops=1, all counters=0.
- Reset mid-byte or mid-image aborts everything. The next start bit is treated as byte 0 of a new header.

Input sync:
- rx passes through 2 flops before use.
- Start-bit detection uses the synchronized signal, so there is a 2-cycle input latency.

Bit FSM (IDLE, START, DATA, STOP):
- IDLE: wait for synchronized rx=0 → START, bit counter cleared.
- START: after CLKS_PER_BIT/2 cycles, re-sample. rx=0 → DATA. rx=1 (glitch) → IDLE, no byte.
- DATA: sample every CLKS_PER_BIT cycles at mid-bit, 8 bits, LSB first. After bit 7 → STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx=1: byte valid, 1-cycle internal byteValid pulse.
  - rx=0: set frameError, discard byte.
  - Either case → IDLE.
  - The next start bit may begin immediately after the stop sample (back-to-back bytes).

Word assembly:
- Big-endian: first byte received → bits 31:24, fourth → bits 7:0.
- A byte-in-word counter (0..3) wraps after the 4th byte.
- A discarded (framing-error) byte does not advance the counter.

Load FSM (HEADER, LOAD, FINISHED):
- HEADER: first complete word is N, the number of instruction words.
  - N=0 → FINISHED on the cycle after the header completes.
  - N>0 → LOAD, wordIndex=0.
- LOAD: on each completed word:
  - If wordIndex < MEM_WORDS: writeEnable=1 for exactly one cycle, the cycle after the 4th byte's byteValid. writeData = word, writeAddress = wordIndex*4 (32-bit arithmetic, no wrap inside the MEM_WORDS range).
  - If wordIndex >= MEM_WORDS: no strobe, but the word is still counted.
  - wordIndex increments.
  - When wordIndex reaches N → FINISHED, on the same cycle as the final strobe's deassertion edge.
- FINISHED:
  - cpuReset=0 and done=1, starting the cycle after the last word completes (or after a zero header).
  - Further rx traffic is parsed (frameError may still set) but produces no writes.
  - Only reset returns the block to HEADER.
- Between strobes, writeAddress and writeData hold their last values.

Test Plan:
1. CLKS_PER_BIT=4. Send header 00 00 00 02, then 8C 01 00 04 and 00 22 18 20 → two strobes: (addr 0x0, data 0x8C010004) and (addr 0x4, data 0x00221820). cpuReset falls and done rises 1 cycle after the second strobe. No frameError.
2. Send header 00 00 00 00 → no writeEnable ever. done=1 and cpuReset=0 one cycle after the 4th header byte's stop sample.
3. Hold rx low through the stop bit of the 2nd data byte of a word, then resend that byte correctly → frameError=1. The word still assembles from the 4 good bytes at the correct address. done still reached.
4. MEM_WORDS=2, header N=3, three words → strobes only at 0x0 and 0x4. The third word is consumed without a strobe. done=1 after the third word.
5. Assert reset after 2 of 4 data bytes of word 1 with N=2 → all outputs return to reset values. A fresh image 00 00 00 01 + DEADBEEF yields a single strobe (addr 0x0, data 0xDEADBEEF) and then done.
6. A 1-cycle low glitch on rx while IDLE → START rejects it: no byte, no counter change, no frameError.
